// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - UART byte stream to frame-buffer word packer
//
// Purpose:
//   Collects BYTES_PER_WORD received bytes (first byte ends up in the MSBs)
//   into one RAM word. Each completed word is written with a single-cycle
//   strobe at an auto-incrementing address that wraps at DEPTH.
//   Optional feature macro: PACKER_TIMEOUT_EN. When it is defined, a partial
//   word that sits idle for TIMEOUT_CYCLES clocks is discarded so that byte
//   alignment recovers after a dropped byte.
//
// Ports:
//   clk          rising-edge system clock
//   reset        asynchronous active-high reset
//   clear        synchronous clear of address and partial word
//   rx_ready     one-cycle pulse, data_in holds a received byte
//   data_in      received byte
//   wr_en        one-cycle RAM write strobe
//   wr_addr      RAM write address
//   wr_data      assembled word, stable while wr_en=1
//   frame_done   one-cycle pulse when the address wraps DEPTH-1 -> 0
//   byte_cnt     bytes held in the current partial word
//   timeout_err  one-cycle pulse when a partial word is discarded

`timescale 1ns/1ps

module uart_word_packer #(
  parameter int BYTES_PER_WORD = 3,
  parameter int DEPTH          = 19200,
  parameter int ADDR_W         = 15,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int W             = 8 * BYTES_PER_WORD,
  localparam int CNT_W         = $clog2(BYTES_PER_WORD + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              rx_ready,
  input  logic [7:0]        data_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [W-1:0]      wr_data,
  output logic              frame_done,
  output logic [CNT_W-1:0]  byte_cnt,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    ADVANCE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(BYTES_PER_WORD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state_q;
  logic [W-1:0]        sr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [W-1:0]        wdata_q;
  logic                wr_en_q;
  logic                frame_done_q;
  logic                timeout_err_q;

  logic [W-1:0]        sr_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                timeout_hit;

  // Shift register with the new byte entering at the LSB end, so the first
  // byte of a word migrates to the MSBs once the word is complete.
  generate
    if (W == 8) begin : g_sr_single
      assign sr_d = data_in;
    end else begin : g_sr_multi
      assign sr_d = {sr_q[W-9:0], data_in};
    end
  endgenerate

  assign cnt_d = cnt_q + CNT_W'(1);

`ifdef PACKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;

  // Only a genuinely partial word idling in COLLECT can time out; a byte
  // arriving on the same edge always wins.
  assign timeout_hit = (state_q == COLLECT) && (cnt_q != '0) && (cnt_q != FULL_CNT)
                       && !rx_ready && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt_q <= '0;
    end else if (clear || rx_ready || timeout_hit || (state_q != COLLECT) || (cnt_q == '0)) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= COLLECT;
      sr_q          <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wr_en_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      wr_en_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      if (clear) begin
        // Clear beats any coincident byte; a write already in progress has
        // its strobe this cycle, but the address is not advanced.
        state_q <= COLLECT;
        sr_q    <= '0;
        cnt_q   <= '0;
        addr_q  <= '0;
      end else begin
        case (state_q)
          COLLECT: begin
            if (cnt_q == FULL_CNT) begin
              // A full word was buffered while the previous write was in
              // flight (only reachable for very short words).
              wdata_q <= sr_q;
              wr_en_q <= 1'b1;
              state_q <= WRITE;
              if (rx_ready) begin
                sr_q  <= sr_d;
                cnt_q <= CNT_W'(1);
              end else begin
                cnt_q <= '0;
              end
            end else if (rx_ready) begin
              sr_q <= sr_d;
              if (cnt_d == FULL_CNT) begin
                wdata_q <= sr_d;
                cnt_q   <= '0;
                wr_en_q <= 1'b1;
                state_q <= WRITE;
              end else begin
                cnt_q <= cnt_d;
              end
            end else if (timeout_hit) begin
              sr_q          <= '0;
              cnt_q         <= '0;
              timeout_err_q <= 1'b1;
            end
          end

          WRITE: begin
            // Bytes arriving now start the next word; wr_data is separate.
            // At most BYTES_PER_WORD bytes can be held back this way.
            if (rx_ready && (cnt_q != FULL_CNT)) begin
              sr_q  <= sr_d;
              cnt_q <= cnt_d;
            end
            frame_done_q <= (addr_q == LAST_ADDR);
            state_q      <= ADVANCE;
          end

          ADVANCE: begin
            if (rx_ready && (cnt_q != FULL_CNT)) begin
              sr_q  <= sr_d;
              cnt_q <= cnt_d;
            end
            addr_q  <= (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            state_q <= COLLECT;
          end

          default: state_q <= COLLECT;
        endcase
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = addr_q;
  assign wr_data     = wdata_q;
  assign frame_done  = frame_done_q;
  assign byte_cnt    = cnt_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_word_packer.sv
// tb/tb_uart_word_packer.sv - scoreboard bench for uart_word_packer

`timescale 1ns/1ps

module tb_uart_word_packer;

  localparam int BPW     = 3;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 100;
  localparam int W       = 8 * BPW;
  localparam int CNT_W   = $clog2(BPW + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              rx_ready = 1'b0;
  logic [7:0]        data_in = 8'h00;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0]      wr_data;
  logic              frame_done;
  logic [CNT_W-1:0]  byte_cnt;
  logic              timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      data;
    logic              fd;
  } exp_t;

  exp_t exp_q[$];

  uart_word_packer #(
    .BYTES_PER_WORD(BPW),
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .clear(clear),
    .rx_ready(rx_ready),
    .data_in(data_in),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_done(frame_done),
    .byte_cnt(byte_cnt),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Stimulus runs on a posedge+1 grid; each call leaves rx_ready high for
  // exactly one sampling edge, so consecutive calls give back-to-back bytes.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b1;
    data_in  = b;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [W-1:0] d, input logic fd);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.fd   = fd;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    for (int i = BPW - 1; i >= 0; i--) begin
      send_byte(w[8*i +: 8]);
      if (i != 0) idle(gap);
    end
  endtask

  // Monitor: pops the scoreboard on every write strobe and checks the
  // frame_done pulse expected in the cycle that follows.
  logic fd_pending = 1'b0;
  logic fd_exp     = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      fd_pending = 1'b0;
    end else begin
      if (fd_pending) begin
        chk("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
        chk("wr_en_single_cycle", {31'd0, wr_en}, 32'd0);
        fd_pending = 1'b0;
      end else if (frame_done) begin
        chk("frame_done_unexpected", {31'd0, frame_done}, 32'd0);
      end
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {31'd0, wr_en}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_data), 32'(e.data));
          fd_pending = 1'b1;
          fd_exp     = e.fd;
        end
      end
    end
  end

  initial begin
    int pulses;
    int budget;

    // Reset state
    #3;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    idle(3);
    reset = 1'b0;
    idle(2);

    // First word with wide gaps, plus write latency and address update
    expect_write(2'd0, 24'h123456, 1'b0);
    send_byte(8'h12);
    chk("cnt_after_1", 32'(byte_cnt), 32'd1);
    idle(20);
    send_byte(8'h34);
    chk("cnt_after_2", 32'(byte_cnt), 32'd2);
    idle(20);
    send_byte(8'h56);
    chk("lat_wr_en", {31'd0, wr_en}, 32'd1);
    chk("lat_cnt_zero", 32'(byte_cnt), 32'd0);
    idle(1);
    chk("adv_addr_held", 32'(wr_addr), 32'd0);
    idle(1);
    chk("addr_after_1", 32'(wr_addr), 32'd1);
    idle(3);

    // Fill the frame and wrap
    expect_write(2'd1, 24'hABCDEF, 1'b0);
    send_word(24'hABCDEF, 2);
    idle(4);
    expect_write(2'd2, 24'h0F1E2D, 1'b0);
    send_word(24'h0F1E2D, 2);
    idle(4);
    expect_write(2'd3, 24'h3C4B5A, 1'b1);
    send_word(24'h3C4B5A, 2);
    idle(4);
    chk("addr_wrapped", 32'(wr_addr), 32'd0);
    expect_write(2'd0, 24'h696877, 1'b0);
    send_word(24'h696877, 2);
    idle(4);

    // Byte arriving in the WRITE cycle starts the next word
    expect_write(2'd1, 24'h112233, 1'b0);
    send_word(24'h112233, 0);
    send_byte(8'hAA);
    chk("b2b_cnt", 32'(byte_cnt), 32'd1);
    idle(3);
    expect_write(2'd2, 24'hAABBCC, 1'b0);
    send_byte(8'hBB);
    send_byte(8'hCC);
    idle(4);
    chk("addr_before_clear", 32'(wr_addr), 32'd3);

    // Clear drops a partial word and beats a coincident byte
    send_byte(8'h77);
    idle(1);
    clear    = 1'b1;
    rx_ready = 1'b1;
    data_in  = 8'h88;
    idle(1);
    clear    = 1'b0;
    rx_ready = 1'b0;
    chk("clear_cnt", 32'(byte_cnt), 32'd0);
    chk("clear_addr", 32'(wr_addr), 32'd0);
    expect_write(2'd0, 24'h010203, 1'b0);
    send_word(24'h010203, 1);
    idle(4);

    // Clear during WRITE: write completes, no advance
    expect_write(2'd1, 24'h445566, 1'b0);
    send_word(24'h445566, 1);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    idle(2);
    chk("clear_in_write_addr", 32'(wr_addr), 32'd0);
    expect_write(2'd0, 24'h999897, 1'b0);
    send_word(24'h999897, 1);
    idle(4);

    // Idle partial word
    send_byte(8'h5A);
    pulses = 0;
    for (int i = 0; i < TIMEOUT + 5; i++) begin
      idle(1);
      if (timeout_err) pulses++;
    end
`ifdef PACKER_TIMEOUT_EN
    chk("timeout_pulses", 32'(pulses), 32'd1);
    chk("timeout_cnt", 32'(byte_cnt), 32'd0);
    expect_write(2'd1, 24'hC0C1C2, 1'b0);
    send_word(24'hC0C1C2, 1);
`else
    chk("timeout_pulses", 32'(pulses), 32'd0);
    chk("timeout_cnt", 32'(byte_cnt), 32'd1);
    expect_write(2'd1, 24'h5AC1C2, 1'b0);
    send_byte(8'hC1);
    idle(1);
    send_byte(8'hC2);
`endif
    idle(4);
    chk("addr_before_reset", 32'(wr_addr), 32'd2);

    // Asynchronous reset mid-word
    send_byte(8'h01);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_word_cnt", 32'(byte_cnt), 32'd0);
    chk("arst_word_addr", 32'(wr_addr), 32'd0);
    chk("arst_word_data", 32'(wr_data), 32'd0);
    chk("arst_word_wr_en", {31'd0, wr_en}, 32'd0);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    // Asynchronous reset during WRITE
    send_word(24'h102030, 1);
    chk("pre_arst_wr_en", {31'd0, wr_en}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_write_wr_en", {31'd0, wr_en}, 32'd0);
    chk("arst_write_data", 32'(wr_data), 32'd0);
    chk("arst_write_addr", 32'(wr_addr), 32'd0);
    chk("arst_write_fd", {31'd0, frame_done}, 32'd0);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle(2);
    expect_write(2'd0, 24'hDEAD01, 1'b0);
    send_word(24'hDEAD01, 1);

    // Drain the scoreboard with a bounded wait
    budget = 50;
    while ((exp_q.size() != 0 || fd_pending) && budget > 0) begin
      idle(1);
      budget--;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
